// File: rtl/mc6847_gen4.sv
// mc6847_gen4: MC6847-style bitmap graphics (256x192, 1bpp/2bpp) scanned out on a 640x480 VGA raster.
// Ports: clk_25 pixel clock; reset_n async active-low; gm/css/inv mode select (sampled at pixel 0);
//        DD/DA synchronous video memory (1-cycle latency); R/G/B colour; HSYNC/VSYNC active-low;
//        FS field sync, present only when VDG_FS_EN is defined.
module mc6847_gen4 #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int VIRT_W   = 256,
  parameter int VIRT_H   = 192,
  parameter int X_SCALE  = 2,
  parameter int Y_SCALE  = 2,
  parameter int ADDR_W   = 14
) (
  input  logic              clk_25,
  input  logic              reset_n,
  input  logic              gm,
  input  logic              css,
  input  logic              inv,
  input  logic [7:0]        DD,
  output logic [ADDR_W-1:0] DA,
  output logic              R,
  output logic              G,
  output logic              B,
  output logic              HSYNC,
  output logic              VSYNC
`ifdef VDG_FS_EN
  , output logic            FS
`endif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int BYTE_PX = 8 * X_SCALE;
  localparam int BW = $clog2(BYTE_PX);
  localparam int X_START = (H_ACTIVE - VIRT_W * X_SCALE) / 2;
  localparam int Y_START = (V_ACTIVE - VIRT_H * Y_SCALE) / 2;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] XS = HW'(X_START);
  localparam logic [HW-1:0] XE = HW'(X_START + VIRT_W * X_SCALE);
  localparam logic [HW-1:0] HA = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS0 = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS1 = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] YS = VW'(Y_START);
  localparam logic [VW-1:0] YE = VW'(Y_START + VIRT_H * Y_SCALE);
  localparam logic [VW-1:0] VA = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS0 = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS1 = VW'(V_ACTIVE + V_FP + V_SYNC);
  typedef struct packed {
    logic          vis;
    logic          win;
    logic          hs;
    logic          vs;
    logic [BW-1:0] sub;
    logic [2:0]    m;
  } stage_t;
  localparam stage_t IDLE = '{vis: 1'b0, win: 1'b0, hs: 1'b1, vs: 1'b1, sub: '0, m: '0};
  logic [HW-1:0]     pc_q, pc_d, hx;
  logic [VW-1:0]     lc_q, lc_d, vy;
  logic [2:0]        lm_q, lm_d, rgb_q, rgb_d, p1;
  logic [1:0]        p2;
  logic [ADDR_W-1:0] da_q, da_d;
  logic              hs_q, vs_q, win;
  stage_t            s1_q, s1_d, s2_q;
  function automatic logic [2:0] pal(input logic c, input logic [1:0] p);
    return c ? (p == 2'd0 ? 3'b111 : p == 2'd1 ? 3'b011 : p == 2'd2 ? 3'b101 : 3'b110)
             : (p == 2'd0 ? 3'b010 : p == 2'd1 ? 3'b110 : p == 2'd2 ? 3'b001 : 3'b100);
  endfunction
  always_comb begin
    pc_d = pc_q == H_LAST ? '0 : pc_q + HW'(1);
    lc_d = pc_q != H_LAST ? lc_q : lc_q == V_LAST ? '0 : lc_q + VW'(1);
    // Mode is taken from the pins only at pixel 0, so a whole line shares one mode.
    lm_d = pc_q == '0 ? {gm, css, inv} : lm_q;
    hx = pc_q - XS;
    vy = lc_q - YS;
    win = pc_q >= XS && pc_q < XE && lc_q >= YS && lc_q < YE;
    // Address of the byte under this pixel; held outside the window so DA moves once per byte.
    da_d = win ? ADDR_W'(32'(vy) / Y_SCALE * (VIRT_W / 8) + 32'(hx) / BYTE_PX) : da_q;
    s1_d = '{vis: pc_q < HA && lc_q < VA, win: win, hs: !(pc_q >= HS0 && pc_q < HS1),
             vs: !(lc_q >= VS0 && lc_q < VS1), sub: hx[BW-1:0], m: lm_d};
    // DD now holds the byte addressed two cycles ago, i.e. the one for the stage-2 pixel.
    p1 = 3'(32'(s2_q.sub) / X_SCALE);
    p2 = 2'(32'(s2_q.sub) / (2 * X_SCALE));
    rgb_d = !s2_q.vis ? 3'b000
          : s2_q.m[2] ? pal(s2_q.m[1], s2_q.win ? {DD[{~p2, 1'b1}], DD[{~p2, 1'b0}]} : 2'b00)
          : (s2_q.win && (DD[~p1] ^ s2_q.m[0])) ? (s2_q.m[1] ? 3'b111 : 3'b010) : 3'b000;
  end
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= '0;
      lc_q <= '0;
      lm_q <= '0;
      da_q <= '0;
      s1_q <= IDLE;
      s2_q <= IDLE;
      rgb_q <= '0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
    end else begin
      pc_q <= pc_d;
      lc_q <= lc_d;
      lm_q <= lm_d;
      da_q <= da_d;
      s1_q <= s1_d;
      s2_q <= s1_q;
      rgb_q <= rgb_d;
      hs_q <= s2_q.hs;
      vs_q <= s2_q.vs;
    end
  end
`ifdef VDG_FS_EN
  logic fs1_q, fs2_q, fs_q;
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      fs1_q <= 1'b1;
      fs2_q <= 1'b1;
      fs_q <= 1'b1;
    end else begin
      fs1_q <= lc_q < VA;
      fs2_q <= fs1_q;
      fs_q <= fs2_q;
    end
  end
  assign FS = fs_q;
`endif
  assign DA = da_q;
  assign {R, G, B} = rgb_q;
  assign HSYNC = hs_q;
  assign VSYNC = vs_q;
endmodule
